alu_seq: RTL and testbench
==========================

# alu_seq

Command sequencer and register file placed directly upstream of the 8-bit ALU. It accepts operation commands over a valid/ready handshake and reads operands from a 4-entry register file. It drives the ALU's operand and opcode inputs, then writes the ALU result back with locally maintained zero/carry flags. Each completed command produces one response beat, which makes the ALU usable as a multi-cycle execution unit.

## Interface
- DATA_W, 8, datapath width; must equal ALU width
- NREG, 4, register-file entries; select fields are clog2(NREG) = 2 bits
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  4  operation; 0x1–0xB are forwarded to the ALU unchanged
- cmd_dst  input  2  destination register
- cmd_srca  input  2  operand-A register
- cmd_srcb  input  2  operand-B register
- cmd_imm  input  8  immediate for op 0x0
- alu_in_a  output  8  to ALU in_a, registered
- alu_in_b  output  8  to ALU in_b, registered
- alu_opcode  output  4  to ALU opcode, registered
- alu_out  input  8  from ALU result
- alu_carry  input  1  from ALU carry
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  value written, or register read
- rsp_zero  output  1  zero flag after command
- rsp_carry  output  1  carry flag after command
- rsp_err  output  1  illegal opcode; no state changed

## Operation
FSM states are IDLE, EXEC and RESP.
- cmd_ready = (state == IDLE), combinational.
- IDLE, on cmd_valid & cmd_ready, decodes cmd_op:
  - 0x1–0xB: latch reg[srca] into alu_in_a, reg[srcb] into alu_in_b and cmd_op into alu_opcode; latch dst; go to EXEC.
  - 0x0 (load immediate): reg[dst] <= cmd_imm; zero <= (cmd_imm == 0); carry <= 0; rsp_data <= cmd_imm; go to RESP. The ALU is not used.
  - 0xC–0xF: rsp_err <= 1; registers and flags are unchanged; rsp_data <= 0; go to RESP. See Configuration for 0xC.
- EXEC (exactly one cycle):
  - reg[dst] <= alu_out, carry <= alu_carry, zero <= (alu_out == 0) computed locally.
  - rsp_data <= alu_out; go to RESP.
  - The alu_* outputs hold their values through EXEC and after it, until the next command issues.
- RESP: rsp_valid = 1; all rsp_* outputs are stable while rsp_valid & !rsp_ready. On rsp_ready, go to IDLE, and rsp_err clears on that exit.
- Operand reads happen at accept, after every prior write has completed, so there is no hazard on read-after-write, including dst == srca == srcb.
- Unary ALU ops (0x3, 0x4, 0x8–0xB) still drive alu_in_b = reg[srcb]; the ALU ignores it.
- rsp_zero and rsp_carry are the flag registers and persist between commands. An error response leaves them unchanged.

## Timing
- Reset (asynchronous assert, synchronous-release assumed upstream):
  - state = IDLE; all registers = 0x00; zero = 0; carry = 0.
  - alu_in_a = alu_in_b = 0x00; alu_opcode = 0x0.
  - rsp_valid = 0, rsp_data = 0x00, rsp_err = 0, cmd_ready = 1.
- Reset during EXEC or RESP aborts the command: no register write, no response.
- ALU op latency: accept edge T0 → alu_* valid in cycle T0+1 → write and rsp_valid at edge T0+2. This is 2 cycles from accept to response.
- Load-immediate and error latency: rsp_valid at edge T0+1.
- Peak throughput with rsp_ready held high: one ALU command per 3 cycles, one load per 2 cycles.
- Backpressure: rsp_ready low stalls the block in RESP indefinitely with cmd_ready = 0. No command is accepted while a response is pending.

## Configuration
- ALU_SEQ_RDREG_EN defined: op 0xC is register read.
  - rsp_data = reg[srca], rsp_err = 0.
  - No write, flags unchanged.
  - Latency is 1 cycle, the same as load.
- ALU_SEQ_RDREG_EN undefined: 0xC is illegal like 0xD–0xF, giving rsp_err = 1 and rsp_data = 0x00.

## Test plan
- Reset, then load: assert reset_n = 0 mid-stream → all rsp_* and alu_* at reset values, cmd_ready = 1. Then load r1 = 0xFF, r2 = 0x01 → two responses, each with rsp_carry = 0 and rsp_zero = 0.
- Add with wrap: ADD r3 = r1 + r2 → alu_in_a = 0xFF, alu_in_b = 0x01, alu_opcode = 0x1 during EXEC. Response at T0+2 has rsp_data = 0x00, rsp_zero = 1, rsp_carry = 1.
- Backpressure: issue SUB r0 = r2 − r1 with rsp_ready low for 5 cycles → rsp_valid and rsp_data = 0x02 stay stable, cmd_ready = 0 throughout, and a held cmd_valid is not consumed. Release rsp_ready → cmd_ready = 1 the next cycle.
- Self-destination: load r1 = 0x55, then XOR r1 = r1 ^ r1 → rsp_data = 0x00, rsp_zero = 1, and a subsequent read of r1 returns 0x00.
- Illegal opcode and flag persistence: issue op 0xE → rsp_err = 1, rsp_data = 0x00, flags equal to those of the prior response, and no register changes. Issue 0xC with the macro defined and srca = r3 → rsp_data = r3, rsp_err = 0. Without the macro, the same 0xC command gives rsp_err = 1.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- command sequencer and register file in front of an 8-bit ALU.
//
// Accepts one command at a time over a valid/ready handshake, reads operands
// from a small register file, drives the external ALU through registered
// operand/opcode outputs, and writes the ALU result back together with local
// zero/carry flags. Every accepted command yields exactly one response beat.
//
// Handshake semantics (both channels): a beat transfers on a rising clk edge
// where valid and ready are both high. The producer keeps valid and its
// payload stable until the transfer. cmd_ready is high only in IDLE. rsp_valid
// is high only in RESP, and the rsp_* payload is held while rsp_ready is low.
//
// Command opcodes:
//   0x0       load immediate: reg[dst] = imm, zero = (imm == 0), carry = 0
//   0x1..0xB  ALU operation: reg[dst] = ALU(reg[srca], reg[srcb], op)
//   0xC       register read when ALU_SEQ_RDREG_EN is defined, else illegal
//   0xD..0xF  illegal: rsp_err = 1, rsp_data = 0, no state change
//
// Build option:
//   ALU_SEQ_RDREG_EN  when defined, op 0xC returns reg[srca] without writing.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_op, cmd_dst, cmd_srca,
//   cmd_srcb, cmd_imm            command payload
//   alu_in_a, alu_in_b,
//   alu_opcode                   registered ALU inputs
//   alu_out, alu_carry           ALU result (combinational, outside this block)
//   rsp_valid / rsp_ready        response handshake
//   rsp_data, rsp_zero,
//   rsp_carry, rsp_err           response payload
//   dbg_state_o                  current FSM state, for observation only
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int SEL_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset_n,
   // command channel
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [SEL_W-1:0]  cmd_dst,
   input  logic [SEL_W-1:0]  cmd_srca,
   input  logic [SEL_W-1:0]  cmd_srcb,
   input  logic [DATA_W-1:0] cmd_imm,
   // ALU side
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   output logic [3:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   // response channel
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic              rsp_err,
   // observation
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_LDI   = 4'h0;
   localparam logic [3:0] OP_ALU_HI = 4'hB;
   localparam logic [3:0] OP_RDREG = 4'hC;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q,    state_d;
   logic [DATA_W-1:0]   rf_q [NREG];
   logic [DATA_W-1:0]   rf_d [NREG];
   logic                zero_q,     zero_d;
   logic                carry_q,    carry_d;
   logic [DATA_W-1:0]   alu_a_q,    alu_a_d;
   logic [DATA_W-1:0]   alu_b_q,    alu_b_d;
   logic [3:0]          alu_op_q,   alu_op_d;
   logic [SEL_W-1:0]    dst_q,      dst_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q,  rsp_err_d;

   logic                cmd_fire;

   assign cmd_fire = cmd_valid && (state_q == ST_IDLE);

   // ---------------------------------------------------------------------------
   // Next-state and datapath decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rf_d       = rf_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      dst_d      = dst_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               if (cmd_op == OP_LDI) begin
                  rf_d[cmd_dst] = cmd_imm;
                  zero_d        = (cmd_imm == '0);
                  carry_d       = 1'b0;
                  rsp_data_d    = cmd_imm;
                  rsp_err_d     = 1'b0;
                  state_d       = ST_RESP;
               end else if (cmd_op <= OP_ALU_HI) begin
                  // Operands are read here, after every earlier write has
                  // landed, so dst == srca == srcb needs no forwarding.
                  // Unary ops still latch reg[srcb]; the ALU ignores it.
                  alu_a_d  = rf_q[cmd_srca];
                  alu_b_d  = rf_q[cmd_srcb];
                  alu_op_d = cmd_op;
                  dst_d    = cmd_dst;
                  state_d  = ST_EXEC;
               end else if (cmd_op == OP_RDREG) begin
`ifdef ALU_SEQ_RDREG_EN
                  rsp_data_d = rf_q[cmd_srca];
                  rsp_err_d  = 1'b0;
`else
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
`endif
                  state_d    = ST_RESP;
               end else begin
                  // Illegal: flags and registers stay as they were.
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = ST_RESP;
               end
            end
         end

         ST_EXEC: begin
            // The ALU is combinational on the registered alu_* outputs, so
            // its result is settled by the end of this single cycle.
            rf_d[dst_q] = alu_out;
            carry_d     = alu_carry;
            zero_d      = (alu_out == '0);
            rsp_data_d  = alu_out;
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_err_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= 4'h0;
         dst_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         dst_q      <= dst_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cmd_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_data    = rsp_data_q;
   assign rsp_zero    = zero_q;
   assign rsp_carry   = carry_q;
   assign rsp_err     = rsp_err_q;
   assign alu_in_a    = alu_a_q;
   assign alu_in_b    = alu_b_q;
   assign alu_opcode  = alu_op_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// A behavioural ALU answers the DUT's alu_* outputs; a reference model keeps
// the register file and flags as plain arrays and derives every expected
// response from the command rules.
// ALU opcodes used by the bench ALU:
//   1 add  2 sub(carry=borrow)  3 inc  4 dec  5 and  6 or  7 xor
//   8 shl  9 shr  A rol  B ror   (3, 4, 8..B are unary)
// -----------------------------------------------------------------------------
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'h0;
   logic [1:0] cmd_dst = 2'd0, cmd_srca = 2'd0, cmd_srcb = 2'd0;
   logic [7:0] cmd_imm = 8'h00;
   logic [7:0] alu_in_a, alu_in_b, alu_out;
   logic [3:0] alu_opcode;
   logic       alu_carry;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       rsp_zero, rsp_carry, rsp_err;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_rf [4];
   logic       m_z, m_c;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
      .cmd_imm(cmd_imm),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .dbg_state_o(dbg_state)
   );

   // returns {carry, result}
   function automatic logic [8:0] alu_f(input logic [3:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      int ai, bi;
      ai = int'(a);
      bi = int'(b);
      case (op)
         4'h1: alu_f = 9'((ai + bi) & 32'h1FF);
         4'h2: alu_f = {(ai < bi), 8'((ai - bi) & 32'hFF)};
         4'h3: alu_f = {(ai == 255), 8'((ai + 1) & 32'hFF)};
         4'h4: alu_f = {(ai == 0), 8'((ai + 255) & 32'hFF)};
         4'h5: alu_f = {1'b0, a & b};
         4'h6: alu_f = {1'b0, a | b};
         4'h7: alu_f = {1'b0, a ^ b};
         4'h8: alu_f = {(ai >= 128), 8'((ai * 2) & 32'hFF)};
         4'h9: alu_f = {(ai % 2 == 1), 8'(ai / 2)};
         4'hA: alu_f = {(ai >= 128), 8'(((ai * 2) & 32'hFF) + ai / 128)};
         4'hB: alu_f = {(ai % 2 == 1), 8'(ai / 2 + (ai % 2) * 128)};
         default: alu_f = 9'h000;
      endcase
   endfunction

   always_comb {alu_carry, alu_out} = alu_f(alu_opcode, alu_in_a, alu_in_b);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_z = 1'b0;
      m_c = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_alu_a",  alu_in_a,   0);
      check("rst_alu_b",  alu_in_b,   0);
      check("rst_alu_op", alu_opcode, 0);
      check("rst_rvalid", rsp_valid,  0);
      check("rst_rdata",  rsp_data,   0);
      check("rst_rerr",   rsp_err,    0);
      check("rst_zero",   rsp_zero,   0);
      check("rst_carry",  rsp_carry,  0);
      check("rst_cready", cmd_ready,  1);
   endtask

   // Issue one command starting at a negedge in IDLE, check latency, payload
   // and backpressure behaviour, and return at a negedge in IDLE.
   task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [7:0] imm, input int stall,
                         input bit hold_cmd);
      logic [7:0] e_data;
      logic       e_err;
      logic [8:0] r;
      bit         is_alu;
      is_alu = (op >= 4'h1 && op <= 4'hB);
      // expected outcome from the command rules
      e_err = 1'b0;
      if (op == 4'h0) begin
         e_data = imm;
      end else if (is_alu) begin
         r = alu_f(op, m_rf[sa], m_rf[sb]);
         e_data = r[7:0];
      end else begin
`ifdef ALU_SEQ_RDREG_EN
         if (op == 4'hC) e_data = m_rf[sa];
         else begin e_data = 8'h00; e_err = 1'b1; end
`else
         e_data = 8'h00;
         e_err  = 1'b1;
`endif
      end

      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
      cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
      rsp_ready = (stall == 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (is_alu) begin
         check("exec_alu_a",  alu_in_a,   m_rf[sa]);
         check("exec_alu_b",  alu_in_b,   m_rf[sb]);
         check("exec_alu_op", alu_opcode, op);
         check("exec_rvalid", rsp_valid,  0);
         check("exec_cready", cmd_ready,  0);
         @(negedge clk);
         m_rf[dst] = r[7:0];
         m_c = r[8];
         m_z = (r[7:0] == 8'h00);
      end else if (op == 4'h0) begin
         m_rf[dst] = imm;
         m_z = (imm == 8'h00);
         m_c = 1'b0;
      end
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data",  rsp_data,  e_data);
      check("rsp_err",   rsp_err,   e_err);
      check("rsp_zero",  rsp_zero,  m_z);
      check("rsp_carry", rsp_carry, m_c);
      if (stall > 0) begin
         if (hold_cmd) begin
            // a competing command that must not be taken while RESP is pending
            cmd_valid = 1'b1; cmd_op = 4'h0; cmd_dst = 2'd0; cmd_imm = 8'hAA;
         end
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_rvalid", rsp_valid, 1);
            check("stall_rdata",  rsp_data,  e_data);
            check("stall_cready", cmd_ready, 0);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      check("post_cready", cmd_ready, 1);
      check("post_rvalid", rsp_valid, 0);
   endtask

   task automatic read_reg(input logic [1:0] idx);
      // observable register read in either build
`ifdef ALU_SEQ_RDREG_EN
      do_cmd(4'hC, 2'd0, idx, 2'd0, 8'h00, 0, 0);
`else
      do_cmd(4'h6, idx, idx, idx, 8'h00, 0, 0);  // OR r=r|r leaves r unchanged
`endif
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset_n = 1'b1;
      @(negedge clk);

      // some history, then reset in the middle of an ALU command
      do_cmd(4'h0, 2'd2, 2'd0, 2'd0, 8'h37, 0, 0);
      do_cmd(4'h0, 2'd3, 2'd0, 2'd0, 8'h80, 0, 0);
      cmd_valid = 1'b1; cmd_op = 4'h1; cmd_dst = 2'd1;
      cmd_srca = 2'd2; cmd_srcb = 2'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      read_reg(2'd2);  // must read back 0 after reset

      // loads, add with wrap
      do_cmd(4'h0, 2'd1, 2'd0, 2'd0, 8'hFF, 0, 0);
      do_cmd(4'h0, 2'd2, 2'd0, 2'd0, 8'h01, 0, 0);
      do_cmd(4'h1, 2'd3, 2'd1, 2'd2, 8'h00, 0, 0);
      check("add_wrap_data", rsp_data, 8'h00);
      check("add_wrap_flags", {rsp_zero, rsp_carry}, 2'b11);

      // SUB r0 = r2 - r1 under 5 cycles of backpressure, competing command held
      do_cmd(4'h2, 2'd0, 2'd2, 2'd1, 8'h00, 5, 1);
      read_reg(2'd0);
      check("sub_not_overwritten", m_rf[0], 8'h02);

      // self-destination XOR
      do_cmd(4'h0, 2'd1, 2'd0, 2'd0, 8'h55, 0, 0);
      do_cmd(4'h7, 2'd1, 2'd1, 2'd1, 8'h00, 0, 0);
      read_reg(2'd1);

      // illegal op keeps flags from the prior response
      do_cmd(4'h1, 2'd2, 2'd3, 2'd2, 8'h00, 0, 0);
      do_cmd(4'hE, 2'd0, 2'd0, 2'd0, 8'h00, 0, 0);
      do_cmd(4'hC, 2'd0, 2'd3, 2'd0, 8'h00, 1, 0);
      for (int i = 0; i < 4; i++) read_reg(2'(i));

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         do_cmd(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0 ? 2 : 0,
                1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) read_reg(2'(i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
